transaction_engine: RTL and testbench

//  Datapath/control stage directly downstream of the main controller. Latches the amount and key

---
 rtl/transaction_engine.sv | 177 +++++++++++++++++
 tb/tb_transaction_engine.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/transaction_engine.sv
// Purpose : latches amount/key from the switches and moves coins from player 1 to player 2 in the balance RAM.
// Latency : DONE is entered on the 8th clock edge (OK) or the 6th (error), counting the edge that samples start.
// Backpr. : none; start is a level held by the main FSM, DONE is held until start drops or reset_others clears.
// Option  : define TXN_FEE_EN to burn FEE coins from player 1 on every accepted transfer.
module transaction_engine #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 2,
    parameter int unsigned P1_ADDR  = 0,
    parameter int unsigned P2_ADDR  = 1,
    parameter int unsigned KEY_ADDR = 2,
    parameter int unsigned FEE      = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              i_reset_others,
    input  logic              i_load_amount,
    input  logic              i_load_key,
    input  logic              i_start_transaction,
    input  logic [DATA_W-1:0] i_sw_in,
    input  logic [DATA_W-1:0] i_mem_rdata,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_wdata,
    output logic              o_mem_we,
    output logic              o_busy,
    output logic              o_finished_transaction,
    output logic [1:0]        o_tx_status,
    output logic [DATA_W-1:0] o_p1_bal,
    output logic [DATA_W-1:0] o_p2_bal
);

    typedef enum logic [3:0] {
        IDLE, RD_KEY, RD_P1, RD_P2, CAP_P2, CHECK, WR_P1, WR_P2, DONE
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_BAD_KEY  = 2'b01;
    localparam logic [1:0] ST_NO_FUNDS = 2'b10;
    localparam logic [1:0] ST_OVERFLOW = 2'b11;

    localparam logic [ADDR_W-1:0] A_P1  = ADDR_W'(P1_ADDR);
    localparam logic [ADDR_W-1:0] A_P2  = ADDR_W'(P2_ADDR);
    localparam logic [ADDR_W-1:0] A_KEY = ADDR_W'(KEY_ADDR);

`ifdef TXN_FEE_EN
    localparam bit FEE_ON = 1'b1;
`else
    localparam bit FEE_ON = 1'b0;
`endif
    // Fee is folded into the cost, one bit wider than the data so it cannot wrap.
    localparam logic [DATA_W:0] FEE_ADD = FEE_ON ? (DATA_W+1)'(FEE) : '0;

    state_t            r_state;
    logic [DATA_W-1:0] r_amount;
    logic [DATA_W-1:0] r_key_q;
    logic [DATA_W-1:0] r_key_mem;
    logic [DATA_W-1:0] r_p1_bal;
    logic [DATA_W-1:0] r_p2_bal;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_we;
    logic              r_finished;
    logic [1:0]        r_tx_status;

    logic [DATA_W:0]   w_cost;
    logic [DATA_W:0]   w_p2_sum;
    logic [DATA_W-1:0] w_p1_new;
    logic              w_bad_key;
    logic              w_no_funds;
    logic              w_overflow;

    // r_p1_bal/r_p2_bal double as the captured operands: after WR_P1 the old p1 is no longer needed.
    assign w_cost     = {1'b0, r_amount} + FEE_ADD;
    assign w_p2_sum   = {1'b0, r_p2_bal} + {1'b0, r_amount};
    assign w_p1_new   = r_p1_bal - w_cost[DATA_W-1:0];
    assign w_bad_key  = (r_key_q != r_key_mem);
    assign w_no_funds = ({1'b0, r_p1_bal} < w_cost);
    assign w_overflow = w_p2_sum[DATA_W];

    // Transaction FSM with all outputs registered alongside the state.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state     <= IDLE;
            r_amount    <= '0;
            r_key_q     <= '0;
            r_key_mem   <= '0;
            r_p1_bal    <= '0;
            r_p2_bal    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_finished  <= 1'b0;
            r_tx_status <= ST_OK;
        end else if (!i_reset_others) begin
            // Display balances survive a soft clear; an abort after WR_P1 is accepted as non-atomic.
            r_state     <= IDLE;
            r_amount    <= '0;
            r_key_q     <= '0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_finished  <= 1'b0;
            r_tx_status <= ST_OK;
        end else begin
            r_mem_we <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_load_amount) r_amount <= i_sw_in;
                    if (i_load_key)    r_key_q  <= i_sw_in;
                    if (i_start_transaction) begin
                        r_state    <= RD_KEY;
                        r_mem_addr <= A_KEY;
                    end
                end
                RD_KEY: begin
                    r_state    <= RD_P1;
                    r_mem_addr <= A_P1;
                end
                RD_P1: begin
                    r_key_mem  <= i_mem_rdata;
                    r_state    <= RD_P2;
                    r_mem_addr <= A_P2;
                end
                RD_P2: begin
                    r_p1_bal <= i_mem_rdata;
                    r_state  <= CAP_P2;
                end
                CAP_P2: begin
                    r_p2_bal <= i_mem_rdata;
                    r_state  <= CHECK;
                end
                CHECK: begin
                    if (w_bad_key || w_no_funds || w_overflow) begin
                        r_state     <= DONE;
                        r_finished  <= 1'b1;
                        r_tx_status <= w_bad_key  ? ST_BAD_KEY :
                                       w_no_funds ? ST_NO_FUNDS : ST_OVERFLOW;
                    end else begin
                        r_state     <= WR_P1;
                        r_tx_status <= ST_OK;
                        r_mem_addr  <= A_P1;
                        r_mem_wdata <= w_p1_new;
                        r_mem_we    <= 1'b1;
                        r_p1_bal    <= w_p1_new;
                    end
                end
                WR_P1: begin
                    r_state     <= WR_P2;
                    r_mem_addr  <= A_P2;
                    r_mem_wdata <= w_p2_sum[DATA_W-1:0];
                    r_mem_we    <= 1'b1;
                    r_p2_bal    <= w_p2_sum[DATA_W-1:0];
                end
                WR_P2: begin
                    r_state    <= DONE;
                    r_finished <= 1'b1;
                end
                DONE: begin
                    if (!i_start_transaction) begin
                        r_state    <= IDLE;
                        r_finished <= 1'b0;
                        r_mem_addr <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_addr             = r_mem_addr;
    assign o_mem_wdata            = r_mem_wdata;
    assign o_mem_we               = r_mem_we;
    assign o_busy                 = (r_state != IDLE);
    assign o_finished_transaction = r_finished;
    assign o_tx_status            = r_tx_status;
    assign o_p1_bal               = r_p1_bal;
    assign o_p2_bal               = r_p2_bal;

endmodule

// File: tb/tb_transaction_engine.sv
// Bench for transaction_engine: table of single transfers plus sequences for
// busy loads, DONE hold, soft reset mid-read and key/amount clearing.
module tb_transaction_engine;

    logic       clock = 1'b0;
    logic       resetn;
    logic       reset_others;
    logic       load_amount;
    logic       load_key;
    logic       start;
    logic [7:0] sw_in;
    logic [7:0] mem_rdata;
    logic [1:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_we;
    logic       busy;
    logic       finished;
    logic [1:0] tx_status;
    logic [7:0] p1_bal;
    logic [7:0] p2_bal;

    always #5 clock = ~clock;

    transaction_engine dut (
        .clock                  (clock),
        .resetn                 (resetn),
        .i_reset_others         (reset_others),
        .i_load_amount          (load_amount),
        .i_load_key             (load_key),
        .i_start_transaction    (start),
        .i_sw_in                (sw_in),
        .i_mem_rdata            (mem_rdata),
        .o_mem_addr             (mem_addr),
        .o_mem_wdata            (mem_wdata),
        .o_mem_we               (mem_we),
        .o_busy                 (busy),
        .o_finished_transaction (finished),
        .o_tx_status            (tx_status),
        .o_p1_bal               (p1_bal),
        .o_p2_bal               (p2_bal)
    );

    // Balance RAM model: synchronous read, one cycle latency, preload port for setup.
    logic [7:0] ram [0:3];
    logic       ram_init;
    logic [7:0] init_p1, init_p2, init_key;
    always @(posedge clock) begin
        if (ram_init) begin
            ram[0] <= init_p1;
            ram[1] <= init_p2;
            ram[2] <= init_key;
            ram[3] <= 8'd0;
        end else if (mem_we) begin
            ram[mem_addr] <= mem_wdata;
        end
        mem_rdata <= ram[mem_addr];
    end

    // Count cycles with the write enable high.
    int   we_cnt;
    logic we_clr;
    always @(negedge clock) begin
        if (we_clr)      we_cnt <= 0;
        else if (mem_we) we_cnt <= we_cnt + 1;
    end

    localparam logic [7:0] F = `ifdef TXN_FEE_EN 8'd1 `else 8'd0 `endif ;

    typedef struct {
        logic [7:0] p1, p2, kmem, amt, key;
        logic [1:0] st;
        logic [7:0] e1, e2;
        int         cyc;
    } vec_t;

    vec_t vecs [8];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic init_ram(input logic [7:0] a, input logic [7:0] b, input logic [7:0] k);
        init_p1 = a; init_p2 = b; init_key = k;
        ram_init = 1'b1;
        tick();
        ram_init = 1'b0;
    endtask

    task automatic load(input logic la, input logic lk, input logic [7:0] v);
        sw_in = v; load_amount = la; load_key = lk;
        tick();
        load_amount = 1'b0; load_key = 1'b0;
    endtask

    task automatic clear_we();
        we_clr = 1'b1;
        tick();
        we_clr = 1'b0;
    endtask

    // Raise start and count edges (including the sampling edge) until finished is seen.
    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!finished && n < 30);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        vecs[0] = '{8'd50,  8'd20,  8'hA5, 8'd10, 8'hA5, 2'b00, 8'd40 - F, 8'd30,  8};
        vecs[1] = '{8'd50,  8'd20,  8'hA5, 8'd10, 8'h5A, 2'b01, 8'd50,     8'd20,  6};
`ifdef TXN_FEE_EN
        vecs[2] = '{8'd5,   8'd0,   8'hA5, 8'd5,  8'hA5, 2'b10, 8'd5,      8'd0,   6};
`else
        vecs[2] = '{8'd5,   8'd0,   8'hA5, 8'd5,  8'hA5, 2'b00, 8'd0,      8'd5,   8};
`endif
        vecs[3] = '{8'd100, 8'd250, 8'hA5, 8'd10, 8'hA5, 2'b11, 8'd100,    8'd250, 6};
        vecs[4] = '{8'd7,   8'd9,   8'h3C, 8'd0,  8'h3C, 2'b00, 8'd7 - F,  8'd9,   8};
        vecs[5] = '{8'd100, 8'd245, 8'h11, 8'd10, 8'h11, 2'b00, 8'd90 - F, 8'd255, 8};
        vecs[6] = '{8'd3,   8'd250, 8'h77, 8'd10, 8'h78, 2'b01, 8'd3,      8'd250, 6};
        vecs[7] = '{8'd3,   8'd250, 8'h77, 8'd10, 8'h77, 2'b10, 8'd3,      8'd250, 6};

        resetn = 1'b0; reset_others = 1'b1; load_amount = 1'b0; load_key = 1'b0;
        start = 1'b0; sw_in = 8'd0; ram_init = 1'b0; we_clr = 1'b1;
        init_p1 = 8'd0; init_p2 = 8'd0; init_key = 8'd0;
        tick(); tick(); tick();
        resetn = 1'b1; we_clr = 1'b0;
        tick();
        chk("rst_busy",     int'(busy),      0);
        chk("rst_finished", int'(finished),  0);
        chk("rst_status",   int'(tx_status), 0);
        chk("rst_we",       int'(mem_we),    0);
        chk("rst_addr",     int'(mem_addr),  0);
        chk("rst_p1_bal",   int'(p1_bal),    0);
        chk("rst_p2_bal",   int'(p2_bal),    0);

        for (int i = 0; i < 8; i++) begin
            init_ram(vecs[i].p1, vecs[i].p2, vecs[i].kmem);
            load(1'b1, 1'b0, vecs[i].amt);
            load(1'b0, 1'b1, vecs[i].key);
            clear_we();
            start = 1'b1;
            wait_done(n);
            chk($sformatf("v%0d_cycles", i), n,                   vecs[i].cyc);
            chk($sformatf("v%0d_status", i), int'(tx_status),     int'(vecs[i].st));
            chk($sformatf("v%0d_writes", i), we_cnt,              (vecs[i].st == 2'b00) ? 2 : 0);
            chk($sformatf("v%0d_ram_p1", i), int'(ram[0]),        int'(vecs[i].e1));
            chk($sformatf("v%0d_ram_p2", i), int'(ram[1]),        int'(vecs[i].e2));
            chk($sformatf("v%0d_p1_bal", i), int'(p1_bal),        int'(vecs[i].e1));
            chk($sformatf("v%0d_p2_bal", i), int'(p2_bal),        int'(vecs[i].e2));
            start = 1'b0;
            tick();
            chk($sformatf("v%0d_idle", i),   int'(busy),          0);
            chk($sformatf("v%0d_fin_lo", i), int'(finished),      0);
            chk($sformatf("v%0d_st_held", i), int'(tx_status),    int'(vecs[i].st));
        end

        // Both loads in one cycle; load while busy ignored; start dropped mid-flight.
        init_ram(8'd50, 8'd20, 8'h05);
        load(1'b1, 1'b1, 8'h05);
        clear_we();
        start = 1'b1;
        tick(); tick();
        start = 1'b0;
        load(1'b1, 1'b1, 8'h20);
        n = 0;
        while (!finished && n < 30) begin
            tick();
            n++;
        end
        chk("seqA_fin",    int'(finished),  1);
        chk("seqA_status", int'(tx_status), 0);
        chk("seqA_ram_p1", int'(ram[0]),    int'(8'd45 - F));
        chk("seqA_ram_p2", int'(ram[1]),    25);
        tick();
        chk("seqA_idle",   int'(busy),      0);

        // Bad key with start held in DONE for 5 cycles.
        init_ram(8'd60, 8'd25, 8'hA5);
        load(1'b1, 1'b0, 8'd10);
        load(1'b0, 1'b1, 8'h5A);
        start = 1'b1;
        wait_done(n);
        chk("seqB_cycles", n, 6);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("seqB_hold%0d", k), int'(finished), 1);
            chk($sformatf("seqB_st%0d", k),   int'(tx_status), 1);
            tick();
        end
        start = 1'b0;
        tick();
        chk("seqB_idle",   int'(busy),      0);
        chk("seqB_fin_lo", int'(finished),  0);

        // Soft reset while in RD_P2: abort, clear status, keep display balances.
        init_ram(8'd50, 8'd20, 8'hA5);
        load(1'b1, 1'b0, 8'd10);
        load(1'b0, 1'b1, 8'hA5);
        clear_we();
        start = 1'b1;
        tick(); tick(); tick();
        chk("seqC_busy",   int'(busy),      1);
        chk("seqC_addr_p2", int'(mem_addr), 1);
        reset_others = 1'b0; start = 1'b0;
        tick();
        chk("seqC_idle",   int'(busy),      0);
        chk("seqC_status", int'(tx_status), 0);
        chk("seqC_addr",   int'(mem_addr),  0);
        reset_others = 1'b1;
        tick(); tick();
        chk("seqC_writes", we_cnt,          0);
        chk("seqC_ram_p1", int'(ram[0]),    50);
        chk("seqC_ram_p2", int'(ram[1]),    20);
        chk("seqC_p1_bal", int'(p1_bal),    60);
        chk("seqC_p2_bal", int'(p2_bal),    25);

        // Key register was cleared by the soft reset, so the stored key no longer matches.
        start = 1'b1;
        wait_done(n);
        chk("seqD_cycles", n,               6);
        chk("seqD_status", int'(tx_status), 1);
        start = 1'b0;
        tick();
        chk("seqD_idle",   int'(busy),      0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
